// File: rtl/fix_checksum_chk.sv
// Streaming FIX checksum generator/checker: accumulates the mod-256 byte sum,
// strips the "10=ddd<SOH>" trailer and reports computed/received values.
module fix_checksum_chk #(
  parameter int unsigned BYTES_PER_BEAT = 1,
  parameter logic [7:0]  SOH            = 8'h01,
  parameter int unsigned LEN_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [8*BYTES_PER_BEAT-1:0] data_i,
  input  logic [BYTES_PER_BEAT-1:0]   keep_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic                        start_i,
  input  logic                        end_i,
  output logic [7:0]                  checksum_o,
  output logic [7:0]                  rx_checksum_o,
  output logic [LEN_W-1:0]            length_o,
  output logic                        done_o,
  output logic                        match_o,
  output logic                        err_fmt_o,
  output logic                        abort_o
);

  localparam int unsigned HIST_N = 7;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, CHECK, REPORT} state_t;

  state_t                      state_q, state_d;
  logic [7:0]                  sum_q, sum_d;
  logic [LEN_W-1:0]            cnt_q, cnt_d;
  logic [HIST_N-1:0][7:0]      hist_q, hist_d;
  logic                        ready_q, ready_d;
  logic [7:0]                  cs_q, cs_d, rx_q, rx_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic                        done_q, done_d, match_q, match_d;
  logic                        err_q, err_d, abort_q, abort_d;

  logic                        beat_ok;
  logic [7:0]                  beat_sum;
  logic [HIST_N-1:0][7:0]      beat_hist;
  logic [CNT_W-1:0]            beat_n;
  logic [LEN_W-1:0]            cnt_base, beat_cnt;
  logic [LEN_W:0]              cnt_ext;

  logic [7:0]                  hist_sum;
  logic [3:0]                  d3, d4, d5;
  logic                        digits_ok, pat_ok;
  logic [9:0]                  value;

  function automatic logic is_dig(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  assign beat_ok = valid_i & ready_q & (|keep_i);

  // Fold kept lanes of this beat into sum, count and history; a start beat begins from zero.
  always_comb begin
    beat_sum  = start_i ? 8'h00 : sum_q;
    beat_hist = start_i ? '0 : hist_q;
    cnt_base  = start_i ? '0 : cnt_q;
    beat_n    = '0;
    for (int i = 0; i < int'(BYTES_PER_BEAT); i++) begin
      if (keep_i[i]) begin
        beat_sum  = beat_sum + data_i[8*i +: 8];
        beat_hist = {beat_hist[HIST_N-2:0], data_i[8*i +: 8]};
        beat_n    = beat_n + CNT_W'(1);
      end
    end
    cnt_ext  = (LEN_W+1)'(cnt_base) + (LEN_W+1)'(beat_n);
    beat_cnt = cnt_ext[LEN_W] ? '1 : cnt_ext[LEN_W-1:0];
  end

  // Trailer decode: hist_q[6] is t0 (oldest), hist_q[0] is t6 (newest).
  always_comb begin
    hist_sum = 8'h00;
    for (int k = 0; k < int'(HIST_N); k++) begin
      hist_sum = hist_sum + hist_q[k];
    end
    d3        = 4'(hist_q[3] - 8'h30);
    d4        = 4'(hist_q[2] - 8'h30);
    d5        = 4'(hist_q[1] - 8'h30);
    digits_ok = is_dig(hist_q[3]) & is_dig(hist_q[2]) & is_dig(hist_q[1]);
    pat_ok    = (hist_q[6] == 8'h31) & (hist_q[5] == 8'h30) & (hist_q[4] == 8'h3D)
              & digits_ok & (hist_q[0] == SOH);
    value     = 10'(d3) * 10'd100 + 10'(d4) * 10'd10 + 10'(d5);
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    hist_d  = hist_q;
    cs_d    = cs_q;
    rx_d    = rx_q;
    len_d   = len_q;
    match_d = match_q;
    err_d   = err_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE, REPORT: begin
        if (state_q == REPORT) state_d = IDLE;
        if (beat_ok && start_i) begin
          sum_d   = beat_sum;
          cnt_d   = beat_cnt;
          hist_d  = beat_hist;
          state_d = end_i ? CHECK : ACCUM;
        end
      end
      ACCUM: begin
        if (beat_ok) begin
          sum_d   = beat_sum;
          cnt_d   = beat_cnt;
          hist_d  = beat_hist;
          abort_d = start_i;
          if (end_i) state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = REPORT;
        done_d  = 1'b1;
        cs_d    = sum_q - hist_sum;
        rx_d    = digits_ok ? value[7:0] : 8'h00;
        len_d   = cnt_q;
        err_d   = ~pat_ok | (value > 10'd255) | (cnt_q < LEN_W'(8));
        match_d = ~err_d & (rx_d == cs_d);
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != CHECK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      hist_q  <= '0;
      ready_q <= 1'b1;
      cs_q    <= '0;
      rx_q    <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
      ready_q <= ready_d;
      cs_q    <= cs_d;
      rx_q    <= rx_d;
      len_q   <= len_d;
      done_q  <= done_d;
      match_q <= match_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign ready_o       = ready_q;
  assign checksum_o    = cs_q;
  assign rx_checksum_o = rx_q;
  assign length_o      = len_q;
  assign done_o        = done_q;
  assign match_o       = match_q;
  assign err_fmt_o     = err_q;
  assign abort_o       = abort_q;

endmodule

// File: doc/fix_checksum_chk.md
Name: fix_checksum_chk

Overview:
Streaming FIX checksum generator/checker, the parametrised successor to the single-byte checksum block.
- Accepts a FIX message 1..N bytes per beat and accumulates the modulo-256 byte sum.
- Strips the mandatory trailer "10=ddd<SOH>" and parses the three ASCII digits.
- Reports computed checksum, received checksum, match and format-error flags.
- Sits between the byte-stream framer and the tag parser; gates message acceptance.

Parameters:
- BYTES_PER_BEAT, 1: bytes per input beat; legal values 1, 2, 4, 8.
- SOH, 8'h01: field delimiter byte.
- LEN_W, 16: width of the message byte counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- data_i  in  8*BYTES_PER_BEAT  message bytes; lane 0 (bits 7:0) is the earliest byte
- keep_i  in  BYTES_PER_BEAT  byte-lane valid; contiguous from lane 0; may be partial only on the end beat
- valid_i  in  1  beat valid
- ready_o  out  1  beat accepted when valid_i & ready_o
- start_i  in  1  qualifies the first beat of a message
- end_i  in  1  qualifies the last beat; the trailer ends in this beat
- checksum_o  out  8  computed checksum (sum of all bytes before "10=", mod 256)
- rx_checksum_o  out  8  parsed trailer value (low 8 bits)
- length_o  out  LEN_W  total accepted bytes, saturating
- done_o  out  1  one-cycle pulse; outputs valid
- match_o  out  1  ~err_fmt_o & (rx == computed); valid with done_o
- err_fmt_o  out  1  malformed trailer; valid with done_o
- abort_o  out  1  one-cycle pulse when a message is abandoned

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all accumulators and outputs 0; ready_o=1.
- States:
  - IDLE: beats without start_i are ignored. A start beat loads the sum and count from that beat and goes to ACCUM, or to CHECK if end_i is also set.
  - ACCUM: add the byte sum of kept lanes each accepted beat. end_i -> CHECK.
  - CHECK: ready_o=0 for exactly one cycle. Computes results -> REPORT.
  - REPORT: done_o=1 with results stable; ready_o=1. A start beat here begins the next message (-> ACCUM/CHECK); otherwise -> IDLE.
- Latency:
  - End beat accepted at edge N; CHECK during cycle N+1; done_o high during cycle N+2.
  - Results hold until the next done_o.
- Arithmetic:
  - The running sum is 8 bits and wraps; no carry is kept.
  - A 7-byte history shift register holds the last 7 accepted bytes, shifting in lane order, up to 8 bytes per beat.
  - checksum = total_sum - sum(last 7 bytes), mod 256.
- Trailer check (on the 7 history bytes t0..t6):
  - Required: t0='1', t1='0', t2='=', t3..t5 in '0'..'9', t6=SOH.
  - Value = 100*d3 + 10*d4 + d5.
  - err_fmt_o=1 if the pattern fails, value > 255, or length < 8 (trailer plus at least one body byte).
  - On error, rx_checksum_o = low 8 bits of the value, or 0 if the digits are invalid.
- length_o counts kept bytes and saturates at 2^LEN_W-1; saturation does not affect the checksum.
- valid_i=0: all state holds, including mid-message.
- start_i while in ACCUM:
  - abort_o pulses the next cycle.
  - The current message is discarded with no done_o.
  - The new message restarts from the start beat.
- Illegal keep_i: keep_i==0 on a valid beat is treated as no beat; a partial keep on a non-end beat is used as given (undefined framing, not checked).
- end_i without a prior start (in IDLE) is ignored.
- Reset mid-message: immediate return to IDLE; no done_o or abort_o.

Test Plan:
- BYTES=1, stream 41 01 "10=066" 01 (start on 0x41, end on the final SOH) -> done_o at N+2, checksum_o=0x42, rx=0x42, match=1, err=0, length=9.
- Same stream with trailer "10=067" -> checksum_o=0x42, rx=0x43, match=0, err=0.
- Wrap: body FF FF 03 then "10=001"<SOH> -> checksum_o=0x01, match=1. Trailer "10=300" -> err_fmt=1, match=0. Trailer "10=2A5" -> err_fmt=1, rx=0.
- BYTES=4, first message over 3 beats, keep 1111, 1111, 0001, valid_i dropped 2 cycles mid-message -> same results as the first scenario. ready_o low one cycle after the end beat. A start beat accepted in the REPORT cycle is processed.
- Abort: start, 3 bytes, new start_i mid-message -> abort_o pulse, no done_o; second message checks correctly.
- Reset asserted asynchronously mid-ACCUM -> outputs 0 immediately; next full message checks correctly.
